// File: rtl/rc_pkg.sv
// Shared types and constants for the result collector.
package rc_pkg;

  // COLLECT: accumulator has room; STALL: accumulator full, holding register busy
  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } rc_state_e;

  localparam int unsigned RC_WIDTH_DEFAULT = 8;

  // Fill counter must represent 0..width inclusive
  function automatic int unsigned rc_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rc_accumulator.sv
// LSB-first bit accumulator with saturating fill counter and clear.
// On clr the word restarts; a simultaneous wr lands at bit 0.
module rc_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             bit_in,
  input  logic             clr,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] fill
);

  // Store incoming bit at position fill, saturating at WIDTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      fill <= '0;
    end else if (clr) begin
      acc  <= {{(WIDTH-1){1'b0}}, wr & bit_in};
      fill <= CNT_W'(wr);
    end else if (wr && fill != CNT_W'(WIDTH)) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (fill == CNT_W'(i)) acc[i] <= bit_in;
      end
      fill <= fill + CNT_W'(1);
    end
  end

endmodule

// File: rtl/result_collector.sv
// Packs ICU result bits into WIDTH-bit words and presents them on a
// valid/ready port, double-buffered (accumulator + holding register).
// Optional macro RESULT_COLLECTOR_PARITY_EN adds out_parity (even parity
// of the held word).
module result_collector
  import rc_pkg::*;
#(
  parameter int unsigned WIDTH = RC_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = rc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             result,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fill,
  output logic             overflow
`ifdef RESULT_COLLECTOR_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  rc_state_e        state, state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word_nx;
  logic             flush_pending;
  logic             full, complete, take, xfer, acc_wr, drop;

  rc_accumulator #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .wr     (acc_wr),
    .bit_in (result),
    .clr    (xfer),
    .acc    (acc),
    .fill   (fill)
  );

  // Transfer decision and next state. The word moved to the holding register
  // already includes this cycle's bit when there is room for it, so a
  // completing write transfers immediately; only a write into an already
  // full accumulator passes through into the fresh word.
  always_comb begin
    full     = (fill == CNT_W'(WIDTH));
    take     = out_valid & out_ready;
    word_nx  = acc;
    if (write && !full) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (fill == CNT_W'(i)) word_nx[i] = result;
      end
    end
    complete = full || (write && fill == CNT_W'(WIDTH - 1));
    xfer     = (complete || ((flush_pending || flush) && fill != '0)) &&
               (!out_valid || take);
    acc_wr   = write && (!xfer || full);
    drop     = write && (state == STALL) && !xfer;
    state_nx = (complete && !xfer) ? STALL : COLLECT;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nx;
  end

  // Holding register, flush request and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      flush_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (xfer) begin
        out_data      <= word_nx;
        out_valid     <= 1'b1;
        flush_pending <= 1'b0;
      end else begin
        if (take) out_valid <= 1'b0;
        if (flush && fill != '0) flush_pending <= 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef RESULT_COLLECTOR_PARITY_EN
  // Parity registered alongside the held word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      out_parity <= 1'b0;
    else if (xfer) out_parity <= ^word_nx;
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Testbench for result_collector: directed steps plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_result_collector;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         write, result, flush, out_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [3:0]   fill;
  logic         overflow;
`ifdef RESULT_COLLECTOR_PARITY_EN
  logic         out_parity;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit           acc_q[$];
  logic [W-1:0] m_data;
  logic         m_valid, m_pend, m_ovf, m_par;

  result_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .result    (result),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow)
`ifdef RESULT_COLLECTOR_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit q[$]);
    logic [W-1:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    acc_q.delete();
    m_data = '0; m_valid = 0; m_pend = 0; m_ovf = 0; m_par = 0;
  endtask

  // One clock of the specified behaviour, from the bit-list point of view
  task automatic model_step(input logic w, input logic r, input logic f, input logic rdy);
    int n;
    bit merged[$];
    bit accept, room, want;
    n      = acc_q.size();
    merged = acc_q;
    accept = m_valid && rdy;
    room   = !m_valid || accept;
    if (w && n < int'(W)) merged.push_back(r);
    want = (merged.size() == int'(W)) || ((m_pend || f) && n > 0);
    if (want && room) begin
      m_data  = pack(merged);
      m_par   = ^m_data;
      m_valid = 1;
      m_pend  = 0;
      acc_q.delete();
      if (w && n == int'(W)) acc_q.push_back(r);
    end else begin
      if (accept) m_valid = 0;
      acc_q = merged;
      if (w && n == int'(W)) m_ovf = 1;
      if (f && n > 0) m_pend = 1;
    end
  endtask

  task automatic check_all();
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("fill",      32'(fill),      32'(acc_q.size()));
    chk("overflow",  32'(overflow),  32'(m_ovf));
`ifdef RESULT_COLLECTOR_PARITY_EN
    chk("out_parity", 32'(out_parity), 32'(m_par));
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic rdy);
    write = w; result = r; flush = f; out_ready = rdy;
    @(posedge clk);
    model_step(w, r, f, rdy);
    #1;
    check_all();
  endtask

  task automatic write_byte(input logic [W-1:0] v, input logic rdy);
    for (int i = 0; i < int'(W); i++) step(1'b1, v[i], 1'b0, rdy);
  endtask

  initial begin
    logic [W-1:0] pat;
    rst = 1'b0; write = 0; result = 0; flush = 0; out_ready = 0;
    model_reset();
    #1;
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_fill",  32'(fill),      32'h0);
    chk("rst_ovf",   32'(overflow),  32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Full word with consumer ready: 1,0,1,1,0,0,1,0 -> 0x4D
    pat = 8'h4D;
    for (int i = 0; i < int'(W) - 1; i++) begin
      step(1'b1, pat[i], 1'b0, 1'b1);
      chk("t1_novalid_yet", 32'(out_valid), 32'h0);
    end
    step(1'b1, pat[W-1], 1'b0, 1'b1);
    chk("t1_data",  32'(out_data),  32'h4D);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_fill",  32'(fill),      32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_accepted", 32'(out_valid), 32'h0);

    // Consumer stalled: two words 0x55, then one dropped bit
    write_byte(8'h55, 1'b0);
    write_byte(8'h55, 1'b0);
    chk("t2_data_held", 32'(out_data), 32'h55);
    chk("t2_fill_full", 32'(fill),     32'h8);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_overflow", 32'(overflow), 32'h1);
    chk("t2_fill_sat", 32'(fill),     32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_second_word", 32'(out_data), 32'h55);
    chk("t2_second_vld",  32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_drained", 32'(out_valid), 32'h0);
    chk("t2_ovf_sticky", 32'(overflow), 32'h1);

    // Partial word flush: 1,1,0 -> 0x03; flush on empty accumulator ignored
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_flush_data",  32'(out_data),  32'h03);
    chk("t3_flush_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_empty_flush", 32'(out_valid), 32'h0);

    // Flush while holding register busy: held pending until ready
    write_byte(8'hA6, 1'b0);
    pat = 8'h1D;
    for (int i = 0; i < 5; i++) step(1'b1, pat[i], 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_pend_data", 32'(out_data), 32'hA6);
    chk("t4_pend_fill", 32'(fill),     32'h5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_partial",   32'(out_data), 32'h1D);
    chk("t4_fill_zero", 32'(fill),     32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_drained", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-word
    write_byte(8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_pre_fill", 32'(fill), 32'h4);
    write = 0; flush = 0; out_ready = 0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("t5_async_data",  32'(out_data),  32'h0);
    chk("t5_async_valid", 32'(out_valid), 32'h0);
    chk("t5_async_fill",  32'(fill),      32'h0);
    chk("t5_async_ovf",   32'(overflow),  32'h0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    write_byte(8'h4D, 1'b1);
    chk("t5_fresh_word", 32'(out_data), 32'h4D);
`ifdef RESULT_COLLECTOR_PARITY_EN
    chk("t6_parity_4d", 32'(out_parity), 32'h0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_word_07", 32'(out_data), 32'h07);
`ifdef RESULT_COLLECTOR_PARITY_EN
    chk("t6_parity_07", 32'(out_parity), 32'h1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
